serpar_frame_tx: RTL

- Serial frame transmitter for the odd-zeros/even-ones parity link.
- Accepts a parallel word over a valid/ready handshake and emits a one-cycle sync slot.
- Then shifts the word out LSB-first and appends one trailer bit.
- The trailer bit makes each complete frame (data + trailer) contain an odd count of 0s and an even count of 1s, so the downstream parity-checker FSM ends the frame in its "yes" state.

---
 rtl/serpar_frame_tx_if.sv | 23 ++
 rtl/serpar_frame_tx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/serpar_frame_tx_if.sv
// Handshake and serial-link signals between a word source and serpar_frame_tx.
// The master side supplies words; the slave side (the transmitter) drives the link.
interface serpar_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             dataout;
  logic             frame_rst;
  logic             frame_valid;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, dataout, frame_rst, frame_valid, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dataout, frame_rst, frame_valid, done
  );
endinterface

// File: rtl/serpar_frame_tx.sv
// Serial frame transmitter: sync slot, WIDTH data bits LSB-first, then a trailer bit
// giving each frame an odd count of 0s and an even count of 1s. Optional macro: SERPAR_B2B_EN.
module serpar_frame_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serpar_frame_tx_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // The trailer rule only balances the frame when WIDTH is even.
  if (((WIDTH % 2) != 0) || (WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $error("serpar_frame_tx: WIDTH must be even and within 2..32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DATA  = 2'd2,
    TRAIL = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zpar_q, zpar_d;
  logic               dataout_q, dataout_d;
  logic               frame_rst_q, frame_rst_d;
  logic               frame_valid_q, frame_valid_d;
  logic               done_q, done_d;
  logic               din_ready_c;
  logic               accept_c;

`ifdef SERPAR_B2B_EN
  assign din_ready_c = ((state_q == IDLE) || (state_q == TRAIL)) && !reset;
`else
  assign din_ready_c = (state_q == IDLE) && !reset;
`endif

  assign accept_c = bus.din_valid && din_ready_c;

  // Outputs are computed for the state being entered so they register with it.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    zpar_d        = zpar_q;
    dataout_d     = 1'b0;
    frame_rst_d   = 1'b0;
    frame_valid_d = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d     = SYNC;
          frame_rst_d = 1'b1;
          shreg_d     = bus.din;
        end
      end

      SYNC: begin
        // Parity and count restart here, already including bit 0.
        state_d       = DATA;
        dataout_d     = shreg_q[0];
        frame_valid_d = 1'b1;
        shreg_d       = shreg_q >> 1;
        cnt_d         = CNT_W'(1);
        zpar_d        = ~shreg_q[0];
      end

      DATA: begin
        frame_valid_d = 1'b1;
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d   = TRAIL;
          dataout_d = zpar_q;
        end else begin
          dataout_d = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          cnt_d     = cnt_q + CNT_W'(1);
          zpar_d    = zpar_q ^ ~shreg_q[0];
        end
      end

      TRAIL: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef SERPAR_B2B_EN
        if (accept_c) begin
          state_d     = SYNC;
          frame_rst_d = 1'b1;
          shreg_d     = bus.din;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      zpar_q        <= 1'b0;
      dataout_q     <= 1'b0;
      frame_rst_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      zpar_q        <= zpar_d;
      dataout_q     <= dataout_d;
      frame_rst_q   <= frame_rst_d;
      frame_valid_q <= frame_valid_d;
      done_q        <= done_d;
    end
  end

  assign bus.din_ready   = din_ready_c;
  assign bus.dataout     = dataout_q;
  assign bus.frame_rst   = frame_rst_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.done        = done_q;

endmodule
